alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational ALU between two requesters: port 0 is the core execute path, port 1 is a secondary client such as an address-generation or debug unit. Each cycle it selects one valid request and drives that request's operands and decode fields into the ALU. It registers the ALU result and returns it to the winning requester through a valid/ready response handshake. Grant order is round-robin by default, or fixed-priority toward port 0.

## Interface
- `FAIR`, default 1: 1 selects round-robin; 0 selects fixed priority, with port 0 always winning.
- `clk` input 1: the only clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid_0` / `req_valid_1` input 1 each: request present. The requester holds all request fields stable until accepted.
- `req_ready_0` / `req_ready_1` output 1 each: request accepted this cycle when ready and valid are both high.
- `req_opcode_N` input 7, `req_funct3_N` input 3, `req_funct7_N` input 7, `req_imm_N` input 12, `req_rs1_N` input 32, `req_rs2_N` input 32 (N = 0, 1): instruction fields and register operands.
- `rsp_valid_0` / `rsp_valid_1` output 1 each: result available for that requester.
- `rsp_ready_0` / `rsp_ready_1` input 1 each: requester consumes the result.
- `rsp_result` output 32: registered ALU result, shared by both ports and qualified by `rsp_valid_N`.
- `alu_opcode` output 7, `alu_funct3` output 3, `alu_funct7` output 7, `alu_imm` output 12, `alu_rs1` output 32, `alu_rs2` output 32: drive the shared ALU.
- `alu_result` input 32: combinational result from the ALU.

## Operation
- State:
  - `last_grant` (1 bit): the port most recently granted.
  - `rsp_owner` (1 bit): the port that owns the held result.
  - `rsp_pend` (1 bit): a result is held.
  - `result_q` (32 bits): the held result.
- `can_issue` = !rsp_pend OR (the owner's `rsp_ready` is high this cycle).
  - A result being drained and a new request being issued may happen in the same cycle.
- Arbitration, evaluated only when `can_issue` is high:
  - Only one port valid: that port wins.
  - Both ports valid, `FAIR`=1: the port not equal to `last_grant` wins.
  - Both ports valid, `FAIR`=0: port 0 wins.
- `req_ready_N` is high only for the winning port and only when `can_issue` is high; at most one ready is high per cycle.
- ALU drive:
  - With a winner, `alu_*` equal the winner's fields combinationally.
  - With no winner, all `alu_*` are 0, which is opcode 0 and therefore ALU-idle.
- On acceptance:
  - `result_q` <= `alu_result`, `rsp_owner` <= winner, `rsp_pend` <= 1, `last_grant` <= winner.
- On drain without a new acceptance: `rsp_pend` <= 0; `result_q` keeps its value.
- `rsp_valid_N` = rsp_pend AND (rsp_owner == N).
- The block does not decode operands. The ALU's arithmetic (width, sign extension, shifts) passes through unchanged; `rsp_result` is exactly the ALU output for the accepted fields.
- Starvation bound with `FAIR`=1: a continuously valid requester is granted within 2 grant opportunities.

## Timing
- Reset value of every output and register:
  - `req_ready_*` = 0, `rsp_valid_*` = 0, `rsp_result` = 0, all `alu_*` = 0.
  - `last_grant` = 1, so port 0 wins the first tie.
  - `rsp_pend` = 0, `rsp_owner` = 0.
- Latency: a request accepted in cycle T has its response valid in cycle T+1.
- Throughput: 1 result per cycle when the owner holds `rsp_ready` high.
- Backpressure: while a result is pending and its owner's `rsp_ready` is low, both `req_ready` outputs are 0 and `alu_*` are 0. `rsp_result` and `rsp_valid` stay stable.
- Same-cycle drain and accept: the new result replaces the old one in T+1 with no bubble. `rsp_owner` may change.
- `rsp_ready_N` while `rsp_valid_N` is low: ignored.
- Reset asserted mid-operation: the pending result is discarded immediately and asynchronously. Requesters must reissue after `rst_n` deasserts; the first grant occurs in the first cycle after release.
- Combinational paths:
  - `req_*` to `alu_*`.
  - `alu_result` to the `result_q` D input.
  - `rsp_ready` to `req_ready`.
  - No path from `alu_result` to any output in the same cycle.

## Test plan
- Port 0 ADDI (opcode 0x13, funct3 0, rs1=5, imm=3), port 1 idle → `req_ready_0`=1 in T; `rsp_valid_0`=1 and `rsp_result`=8 in T+1.
- Both ports issue continuously with `FAIR`=1: port 0 ADD 2+2, port 1 SUB (opcode 0x33, funct7 0x20) 9−4 → grants alternate 0,1,0,1; results alternate 4,5; each result goes to the correct `rsp_valid_N`.
- Same stimulus with `FAIR`=0 → port 0 granted every cycle; `req_ready_1` stays 0 throughout.
- Port 0 result pending with `rsp_ready_0`=0 for 3 cycles while port 1 is valid → no grant for 3 cycles, `rsp_result` held, `alu_*`=0. When `rsp_ready_0` rises, port 1 is granted in that same cycle and its result appears the next cycle.
- Pull `rst_n` low while `rsp_valid_1`=1 → `rsp_valid_1`, `rsp_result` and `req_ready_*` go to 0 immediately without waiting for a clock edge. After release, a simultaneous request from both ports grants port 0 first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; response is valid one cycle after acceptance.
// A held result whose owner is not ready blocks both request ports and forces the ALU inputs to idle.
module alu_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [6:0]  req_opcode_0,
    input  logic [2:0]  req_funct3_0,
    input  logic [6:0]  req_funct7_0,
    input  logic [11:0] req_imm_0,
    input  logic [31:0] req_rs1_0,
    input  logic [31:0] req_rs2_0,

    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [6:0]  req_opcode_1,
    input  logic [2:0]  req_funct3_1,
    input  logic [6:0]  req_funct7_1,
    input  logic [11:0] req_imm_1,
    input  logic [31:0] req_rs1_1,
    input  logic [31:0] req_rs2_1,

    output logic        rsp_valid_0,
    input  logic        rsp_ready_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_1,
    output logic [31:0] rsp_result,

    output logic [6:0]  alu_opcode,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    output logic [11:0] alu_imm,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    input  logic [31:0] alu_result
);

    logic        last_grant_q, last_grant_d;
    logic        rsp_owner_q,  rsp_owner_d;
    logic        rsp_pend_q,   rsp_pend_d;
    logic [31:0] result_q,     result_d;

    logic can_issue;
    logic owner_rdy;
    logic win_vld;
    logic win_sel;

    assign owner_rdy = rsp_owner_q ? rsp_ready_1 : rsp_ready_0;
    assign can_issue = !rsp_pend_q || owner_rdy;

    // Gating with rst_n keeps ready and ALU drive low while reset is held.
    always_comb begin
        win_vld = 1'b0;
        win_sel = 1'b0;
        if (rst_n && can_issue) begin
            if (req_valid_0 && req_valid_1) begin
                win_vld = 1'b1;
                win_sel = FAIR ? ~last_grant_q : 1'b0;
            end else if (req_valid_0) begin
                win_vld = 1'b1;
                win_sel = 1'b0;
            end else if (req_valid_1) begin
                win_vld = 1'b1;
                win_sel = 1'b1;
            end
        end
    end

    assign req_ready_0 = win_vld && !win_sel;
    assign req_ready_1 = win_vld &&  win_sel;

    always_comb begin
        alu_opcode = '0;
        alu_funct3 = '0;
        alu_funct7 = '0;
        alu_imm    = '0;
        alu_rs1    = '0;
        alu_rs2    = '0;
        if (win_vld) begin
            if (win_sel) begin
                alu_opcode = req_opcode_1;
                alu_funct3 = req_funct3_1;
                alu_funct7 = req_funct7_1;
                alu_imm    = req_imm_1;
                alu_rs1    = req_rs1_1;
                alu_rs2    = req_rs2_1;
            end else begin
                alu_opcode = req_opcode_0;
                alu_funct3 = req_funct3_0;
                alu_funct7 = req_funct7_0;
                alu_imm    = req_imm_0;
                alu_rs1    = req_rs1_0;
                alu_rs2    = req_rs2_0;
            end
        end
    end

    // Acceptance takes precedence over drain so a same-cycle swap has no bubble.
    always_comb begin
        last_grant_d = last_grant_q;
        rsp_owner_d  = rsp_owner_q;
        rsp_pend_d   = rsp_pend_q;
        result_d     = result_q;
        if (win_vld) begin
            result_d     = alu_result;
            rsp_owner_d  = win_sel;
            rsp_pend_d   = 1'b1;
            last_grant_d = win_sel;
        end else if (rsp_pend_q && owner_rdy) begin
            rsp_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            rsp_owner_q  <= 1'b0;
            rsp_pend_q   <= 1'b0;
            result_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_owner_q  <= rsp_owner_d;
            rsp_pend_q   <= rsp_pend_d;
            result_q     <= result_d;
        end
    end

    assign rsp_valid_0 = rsp_pend_q && !rsp_owner_q;
    assign rsp_valid_1 = rsp_pend_q &&  rsp_owner_q;
    assign rsp_result  = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter side by side, each with its own small ALU.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_valid_0, req_valid_1;
    logic [6:0]  req_opcode_0, req_opcode_1;
    logic [2:0]  req_funct3_0, req_funct3_1;
    logic [6:0]  req_funct7_0, req_funct7_1;
    logic [11:0] req_imm_0, req_imm_1;
    logic [31:0] req_rs1_0, req_rs1_1, req_rs2_0, req_rs2_1;
    logic        rsp_ready_0, rsp_ready_1;

    logic        f_rdy0, f_rdy1, f_rv0, f_rv1, p_rdy0, p_rdy1, p_rv0, p_rv1;
    logic [31:0] f_res, p_res;
    logic [6:0]  f_op, p_op, f_f7, p_f7;
    logic [2:0]  f_f3, p_f3;
    logic [11:0] f_imm, p_imm;
    logic [31:0] f_rs1, f_rs2, p_rs1, p_rs2, f_alu, p_alu;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] alu_model(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [11:0] imm,
                                              input logic [31:0] a, input logic [31:0] b);
        if (op == 7'h13 && f3 == 3'd0) return a + {{20{imm[11]}}, imm};
        if (op == 7'h33 && f3 == 3'd0) return (f7 == 7'h20) ? a - b : a + b;
        return 32'd0;
    endfunction

    assign f_alu = alu_model(f_op, f_f3, f_f7, f_imm, f_rs1, f_rs2);
    assign p_alu = alu_model(p_op, p_f3, p_f7, p_imm, p_rs1, p_rs2);

    alu_arbiter #(.FAIR(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(f_rdy0), .req_opcode_0(req_opcode_0),
        .req_funct3_0(req_funct3_0), .req_funct7_0(req_funct7_0), .req_imm_0(req_imm_0),
        .req_rs1_0(req_rs1_0), .req_rs2_0(req_rs2_0),
        .req_valid_1(req_valid_1), .req_ready_1(f_rdy1), .req_opcode_1(req_opcode_1),
        .req_funct3_1(req_funct3_1), .req_funct7_1(req_funct7_1), .req_imm_1(req_imm_1),
        .req_rs1_1(req_rs1_1), .req_rs2_1(req_rs2_1),
        .rsp_valid_0(f_rv0), .rsp_ready_0(rsp_ready_0), .rsp_valid_1(f_rv1),
        .rsp_ready_1(rsp_ready_1), .rsp_result(f_res),
        .alu_opcode(f_op), .alu_funct3(f_f3), .alu_funct7(f_f7), .alu_imm(f_imm),
        .alu_rs1(f_rs1), .alu_rs2(f_rs2), .alu_result(f_alu)
    );

    alu_arbiter #(.FAIR(1'b0)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(p_rdy0), .req_opcode_0(req_opcode_0),
        .req_funct3_0(req_funct3_0), .req_funct7_0(req_funct7_0), .req_imm_0(req_imm_0),
        .req_rs1_0(req_rs1_0), .req_rs2_0(req_rs2_0),
        .req_valid_1(req_valid_1), .req_ready_1(p_rdy1), .req_opcode_1(req_opcode_1),
        .req_funct3_1(req_funct3_1), .req_funct7_1(req_funct7_1), .req_imm_1(req_imm_1),
        .req_rs1_1(req_rs1_1), .req_rs2_1(req_rs2_1),
        .rsp_valid_0(p_rv0), .rsp_ready_0(rsp_ready_0), .rsp_valid_1(p_rv1),
        .rsp_ready_1(rsp_ready_1), .rsp_result(p_res),
        .alu_opcode(p_op), .alu_funct3(p_f3), .alu_funct7(p_f7), .alu_imm(p_imm),
        .alu_rs1(p_rs1), .alu_rs2(p_rs2), .alu_result(p_alu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v0, v1, rr0, rr1;
        logic        f_rdy0, f_rdy1, f_rv0, f_rv1;
        logic [31:0] f_res;
        logic        p_rdy0, p_rdy1, p_rv0, p_rv1;
        logic [31:0] p_res;
    } vec_t;

    vec_t vecs[15];

    task automatic set_add_sub();
        req_opcode_0 = 7'h33; req_funct3_0 = 3'd0; req_funct7_0 = 7'h00; req_imm_0 = 12'd0;
        req_rs1_0 = 32'd2;    req_rs2_0 = 32'd2;
        req_opcode_1 = 7'h33; req_funct3_1 = 3'd0; req_funct7_1 = 7'h20; req_imm_1 = 12'd0;
        req_rs1_1 = 32'd9;    req_rs2_1 = 32'd4;
    endtask

    initial begin
        vecs[0]  = '{1,1,1,1, 0,1,0,1, 32'd5, 1,0,1,0, 32'd4};
        vecs[1]  = '{1,1,1,1, 1,0,1,0, 32'd4, 1,0,1,0, 32'd4};
        vecs[2]  = '{1,1,1,1, 0,1,0,1, 32'd5, 1,0,1,0, 32'd4};
        vecs[3]  = '{1,1,1,1, 1,0,1,0, 32'd4, 1,0,1,0, 32'd4};
        vecs[4]  = '{0,1,1,1, 0,1,0,1, 32'd5, 0,1,0,1, 32'd5};
        vecs[5]  = '{0,0,1,1, 0,0,0,0, 32'd5, 0,0,0,0, 32'd5};
        vecs[6]  = '{1,0,1,1, 1,0,1,0, 32'd4, 1,0,1,0, 32'd4};
        vecs[7]  = '{0,1,0,1, 0,0,1,0, 32'd4, 0,0,1,0, 32'd4};
        vecs[8]  = '{0,1,0,1, 0,0,1,0, 32'd4, 0,0,1,0, 32'd4};
        vecs[9]  = '{0,1,0,1, 0,0,1,0, 32'd4, 0,0,1,0, 32'd4};
        vecs[10] = '{0,1,1,1, 0,1,0,1, 32'd5, 0,1,0,1, 32'd5};
        vecs[11] = '{1,1,1,1, 1,0,1,0, 32'd4, 1,0,1,0, 32'd4};
        vecs[12] = '{1,1,0,1, 0,0,1,0, 32'd4, 0,0,1,0, 32'd4};
        vecs[13] = '{1,1,1,1, 0,1,0,1, 32'd5, 1,0,1,0, 32'd4};
        vecs[14] = '{0,1,1,0, 0,0,0,1, 32'd5, 0,1,0,1, 32'd5};

        rst_n = 1'b0;
        req_valid_0 = 1'b1; req_valid_1 = 1'b0;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        set_add_sub();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset f_rdy0", {31'd0, f_rdy0}, 32'd0);
        check("reset p_rdy0", {31'd0, p_rdy0}, 32'd0);
        check("reset f_rv0", {31'd0, f_rv0}, 32'd0);
        check("reset f_rv1", {31'd0, f_rv1}, 32'd0);
        check("reset f_res", f_res, 32'd0);
        check("reset f_op", {25'd0, f_op}, 32'd0);
        check("reset f_rs1", f_rs1, 32'd0);

        // ADDI 5 + 3 on port 0 right after reset release.
        req_opcode_0 = 7'h13; req_funct3_0 = 3'd0; req_funct7_0 = 7'h00;
        req_imm_0 = 12'd3; req_rs1_0 = 32'd5; req_rs2_0 = 32'd0;
        rst_n = 1'b1;
        #1;
        check("addi rdy0", {31'd0, f_rdy0}, 32'd1);
        check("addi rdy1", {31'd0, f_rdy1}, 32'd0);
        check("addi alu_op", {25'd0, f_op}, 32'h13);
        check("addi alu_imm", {20'd0, f_imm}, 32'd3);
        @(posedge clk); #1;
        check("addi rv0", {31'd0, f_rv0}, 32'd1);
        check("addi res", f_res, 32'd8);
        check("addi p_res", p_res, 32'd8);

        set_add_sub();
        for (int i = 0; i < 15; i++) begin
            req_valid_0 = vecs[i].v0;  req_valid_1 = vecs[i].v1;
            rsp_ready_0 = vecs[i].rr0; rsp_ready_1 = vecs[i].rr1;
            #1;
            check($sformatf("v%0d f_rdy0", i), {31'd0, f_rdy0}, {31'd0, vecs[i].f_rdy0});
            check($sformatf("v%0d f_rdy1", i), {31'd0, f_rdy1}, {31'd0, vecs[i].f_rdy1});
            check($sformatf("v%0d p_rdy0", i), {31'd0, p_rdy0}, {31'd0, vecs[i].p_rdy0});
            check($sformatf("v%0d p_rdy1", i), {31'd0, p_rdy1}, {31'd0, vecs[i].p_rdy1});
            check($sformatf("v%0d f_op", i), {25'd0, f_op},
                  (vecs[i].f_rdy0 || vecs[i].f_rdy1) ? 32'h33 : 32'd0);
            check($sformatf("v%0d f_f7", i), {25'd0, f_f7}, vecs[i].f_rdy1 ? 32'h20 : 32'd0);
            check($sformatf("v%0d p_op", i), {25'd0, p_op},
                  (vecs[i].p_rdy0 || vecs[i].p_rdy1) ? 32'h33 : 32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d f_rv0", i), {31'd0, f_rv0}, {31'd0, vecs[i].f_rv0});
            check($sformatf("v%0d f_rv1", i), {31'd0, f_rv1}, {31'd0, vecs[i].f_rv1});
            check($sformatf("v%0d f_res", i), f_res, vecs[i].f_res);
            check($sformatf("v%0d p_rv0", i), {31'd0, p_rv0}, {31'd0, vecs[i].p_rv0});
            check($sformatf("v%0d p_rv1", i), {31'd0, p_rv1}, {31'd0, vecs[i].p_rv1});
            check($sformatf("v%0d p_res", i), p_res, vecs[i].p_res);
        end

        // Asynchronous reset while port 1 holds a result; checked before any clock edge.
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
        #1;
        check("pre-rst f_rv1", {31'd0, f_rv1}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst f_rv1", {31'd0, f_rv1}, 32'd0);
        check("arst f_res", f_res, 32'd0);
        check("arst f_rdy0", {31'd0, f_rdy0}, 32'd0);
        check("arst f_rdy1", {31'd0, f_rdy1}, 32'd0);
        check("arst p_rv1", {31'd0, p_rv1}, 32'd0);
        check("arst f_op", {25'd0, f_op}, 32'd0);
        @(posedge clk); #1;
        rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
        rst_n = 1'b1;
        #1;
        check("post-rst f_rdy0", {31'd0, f_rdy0}, 32'd1);
        check("post-rst f_rdy1", {31'd0, f_rdy1}, 32'd0);
        @(posedge clk); #1;
        check("post-rst f_rv0", {31'd0, f_rv0}, 32'd1);
        check("post-rst f_res", f_res, 32'd4);
        #1;
        check("post-rst 2nd f_rdy1", {31'd0, f_rdy1}, 32'd1);
        @(posedge clk); #1;
        check("post-rst 2nd f_rv1", {31'd0, f_rv1}, 32'd1);
        check("post-rst 2nd f_res", f_res, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
